// File: rtl/vga_frame_scheduler_if.sv
// Signal bundle between the VGA frame scheduler and its neighbours:
// mode controls, life-engine handshake, raster decodes and bank select.
interface vga_frame_scheduler_if;
  logic        run;
  logic [7:0]  genDivider;
  logic        stepReq;
  logic        engineDone;
  logic        clrOverrun;
  logic [11:0] hCount;
  logic [11:0] vCount;
  logic        hSync;
  logic        vSync;
  logic        videoOn;
  logic        frameStart;
  logic        engineStart;
  logic        engineBusy;
  logic        displayBank;
  logic        bufferSwap;
  logic        overrun;

  modport master (
    input  run, genDivider, stepReq, engineDone, clrOverrun,
    output hCount, vCount, hSync, vSync, videoOn, frameStart,
           engineStart, engineBusy, displayBank, bufferSwap, overrun
  );

  modport slave (
    output run, genDivider, stepReq, engineDone, clrOverrun,
    input  hCount, vCount, hSync, vSync, videoOn, frameStart,
           engineStart, engineBusy, displayBank, bufferSwap, overrun
  );
endinterface

// File: rtl/vga_frame_scheduler.sv
// VGA raster timing plus Game-of-Life generation scheduling; the front/back
// bank flips only at the start of vertical blanking.
module vga_frame_scheduler #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input logic                   pixelClk,
  input logic                   rstN,
  vga_frame_scheduler_if.master bus
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] HS_FIRST = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_LAST  = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_LAST  = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COMPUTE   = 2'd1;
  localparam logic [1:0] SWAP_WAIT = 2'd2;

  logic [11:0] hCnt, vCnt;
  logic        hSyncR, vSyncR, videoOnR, frameStartR;
  logic [7:0]  frameCnt;
  logic [7:0]  divEff;
  logic        divHit;
  logic        due;
  logic [1:0]  state, stateNext;
  logic        engineStartR, engineBusyR, displayBankR, bufferSwapR, overrunR;
  logic        vblankEvent;

  assign vblankEvent = (hCnt == '0) && (vCnt == V_VIS);
  assign divEff      = (bus.genDivider == '0) ? 8'd1 : bus.genDivider;
  assign divHit      = ({1'b0, frameCnt} + 9'd1) >= {1'b0, divEff};

  always_ff @(posedge pixelClk) begin
    if (!rstN) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == H_LAST) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 12'd1;
    end else begin
      hCnt <= hCnt + 12'd1;
    end
  end

  always_ff @(posedge pixelClk) begin
    if (!rstN) begin
      hSyncR      <= 1'b1;
      vSyncR      <= 1'b1;
      videoOnR    <= 1'b0;
      frameStartR <= 1'b0;
    end else begin
      hSyncR      <= !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
      vSyncR      <= !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));
      videoOnR    <= (hCnt < H_VIS) && (vCnt < V_VIS);
      frameStartR <= (hCnt == '0) && (vCnt == '0);
    end
  end

  // due is a single-cycle pulse: it either starts a generation or is counted as an overrun
  always_ff @(posedge pixelClk) begin
    if (!rstN) begin
      frameCnt <= '0;
      due      <= 1'b0;
    end else begin
      due <= 1'b0;
      if (!bus.run) begin
        frameCnt <= '0;
        due      <= bus.stepReq;
      end else if (frameStartR) begin
        if (divHit) begin
          frameCnt <= '0;
          due      <= 1'b1;
        end else begin
          frameCnt <= frameCnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (due)            stateNext = COMPUTE;
      COMPUTE:   if (bus.engineDone) stateNext = SWAP_WAIT;
      SWAP_WAIT: if (vblankEvent)    stateNext = IDLE;
      default:                       stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pixelClk) begin
    if (!rstN) begin
      state        <= IDLE;
      engineStartR <= 1'b0;
      engineBusyR  <= 1'b0;
      displayBankR <= 1'b0;
      bufferSwapR  <= 1'b0;
      overrunR     <= 1'b0;
    end else begin
      state        <= stateNext;
      engineBusyR  <= (stateNext != IDLE);
      engineStartR <= (state == IDLE) && due;
      bufferSwapR  <= (state == SWAP_WAIT) && vblankEvent;
      if ((state == SWAP_WAIT) && vblankEvent)
        displayBankR <= ~displayBankR;
      if (due && (state != IDLE))
        overrunR <= 1'b1;
      else if (bus.clrOverrun)
        overrunR <= 1'b0;
    end
  end

  assign bus.hCount      = hCnt;
  assign bus.vCount      = vCnt;
  assign bus.hSync       = hSyncR;
  assign bus.vSync       = vSyncR;
  assign bus.videoOn     = videoOnR;
  assign bus.frameStart  = frameStartR;
  assign bus.engineStart = engineStartR;
  assign bus.engineBusy  = engineBusyR;
  assign bus.displayBank = displayBankR;
  assign bus.bufferSwap  = bufferSwapR;
  assign bus.overrun     = overrunR;
endmodule
